// File: rtl/pdb_pkg.sv
// Shared types and helpers for the pulse-ox post-FFT spectral buffer:
// FSM encoding, port-width derivation and the output shift/saturate.
package pdb_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ACCUM = 1'b1
  } pdb_state_t;

  function automatic int pdb_ch_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  function automatic int pdb_a_w(input int fft_n);
    return (fft_n > 1) ? $clog2(fft_n) : 1;
  endfunction

  // Magnitudes are unsigned, so saturation only needs an upper clamp.
  function automatic logic [63:0] pdb_shift_sat(input logic [63:0] mag, input int shift,
                                                input int out_w);
    logic [63:0] shifted;
    logic [63:0] limit;
    shifted = mag >> shift;
    limit   = (64'd1 << out_w) - 64'd1;
    return (shifted > limit) ? limit : shifted;
  endfunction

endpackage

// File: rtl/pdb_mag_est.sv
// Two-stage alpha-max-beta-min magnitude estimator (max + min/2) with a
// sideband tag carried alongside the data.
module pdb_mag_est
  import pdb_pkg::*;
#(
  parameter int IQ_W  = 24,
  parameter int TAG_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   vld,
  input  logic [TAG_W-1:0]       tag,
  input  logic signed [IQ_W-1:0] i_data,
  input  logic signed [IQ_W-1:0] q_data,
  output logic                   mag_vld,
  output logic [TAG_W-1:0]       mag_tag,
  output logic [IQ_W:0]          mag
);
  localparam int MAG_W = IQ_W + 1;

  // The most negative input maps to 2^(IQ_W-1), which still fits unsigned IQ_W.
  function automatic logic [IQ_W-1:0] abs_u(input logic signed [IQ_W-1:0] v);
    return v[IQ_W-1] ? IQ_W'(-v) : IQ_W'(v);
  endfunction

  logic [IQ_W-1:0]  a_p1, b_p1;
  logic [TAG_W-1:0] tag_p1, tag_p2;
  logic [MAG_W-1:0] mag_p2;
  logic             vld_p1, vld_p2;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p1 <= vld;
      vld_p2 <= vld_p1;
    end
  end

  // p1: absolute values
  always_ff @(posedge clk) begin
    a_p1   <= abs_u(i_data);
    b_p1   <= abs_u(q_data);
    tag_p1 <= tag;
  end

  // p2: max + min/2
  always_ff @(posedge clk) begin
    if (a_p1 >= b_p1) mag_p2 <= {1'b0, a_p1} + MAG_W'(b_p1 >> 1);
    else              mag_p2 <= {1'b0, b_p1} + MAG_W'(a_p1 >> 1);
    tag_p2 <= tag_p1;
  end

  assign mag_vld = vld_p2;
  assign mag_tag = tag_p2;
  assign mag     = mag_p2;

endmodule

// File: rtl/pdb_spectral_buffer.sv
// Post-FFT spectral buffer: per-bin magnitude into a per-channel spectrum RAM,
// plus a per-frame DC (bin 0) / AC (band peak) report for the SpO2 ratio logic.
module pdb_spectral_buffer
  import pdb_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int FFT_N  = 2048,
  parameter int IQ_W   = 24,
  parameter int OUT_W  = 22,
  parameter int SHIFT  = 3,
  parameter int BIN_LO = 1,
  parameter int BIN_HI = FFT_N / 2 - 1,
  parameter int CH_W   = pdb_ch_w(NUM_CH),
  parameter int A_W    = pdb_a_w(FFT_N)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   fft_out_data,
  input  logic                   fft_sop,
  input  logic [CH_W-1:0]        fft_ch,
  input  logic signed [IQ_W-1:0] Iout,
  input  logic signed [IQ_W-1:0] Qout,
  output logic [OUT_W-1:0]       AC_component,
  output logic [OUT_W-1:0]       DC_component,
  output logic [A_W-1:0]         peak_bin,
  output logic [CH_W-1:0]        out_ch,
  output logic                   new_comp_DV,
  output logic                   frame_err,
  output logic                   pdb_done,
  input  logic                   pdb_ack,
  input  logic                   rd_en,
  input  logic [CH_W-1:0]        rd_ch,
  input  logic [A_W-1:0]         rd_addr,
  output logic [IQ_W:0]          rd_data
);
  localparam int MAG_W = IQ_W + 1;
  localparam int TAG_W = CH_W + A_W;
  localparam logic [A_W-1:0] LAST_BIN = A_W'(FFT_N - 1);

  pdb_state_t       state, state_nxt;
  logic [A_W-1:0]   bin_cnt, bin_nxt, take_bin;
  logic [CH_W-1:0]  ch_cur, ch_nxt, take_ch;
  logic             take, abort;

  always_ff @(posedge clk) begin
    if (reset_n) begin
      state   <= S_IDLE;
      bin_cnt <= '0;
      ch_cur  <= '0;
    end else begin
      state   <= state_nxt;
      bin_cnt <= bin_nxt;
      ch_cur  <= ch_nxt;
    end
  end

  // A sop while accumulating drops the partial frame and restarts at bin 0.
  always_comb begin
    state_nxt = state;
    bin_nxt   = bin_cnt;
    ch_nxt    = ch_cur;
    take      = 1'b0;
    abort     = 1'b0;
    take_bin  = bin_cnt;
    take_ch   = ch_cur;
    case (state)
      S_IDLE: begin
        if (fft_out_data && fft_sop) begin
          take      = 1'b1;
          take_bin  = '0;
          take_ch   = fft_ch;
          ch_nxt    = fft_ch;
          bin_nxt   = A_W'(1);
          state_nxt = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (fft_out_data) begin
          take = 1'b1;
          if (fft_sop) begin
            abort    = 1'b1;
            take_bin = '0;
            take_ch  = fft_ch;
            ch_nxt   = fft_ch;
            bin_nxt  = A_W'(1);
          end else begin
            bin_nxt = bin_cnt + A_W'(1);
            if (bin_cnt == LAST_BIN) state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // p0: input sample with its {channel, bin} tag
  logic                   vld_p0;
  logic signed [IQ_W-1:0] i_p0, q_p0;
  logic [TAG_W-1:0]       tag_p0;

  always_ff @(posedge clk) begin
    if (reset_n) begin
      vld_p0    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      vld_p0    <= take;
      frame_err <= abort;
    end
  end

  always_ff @(posedge clk) begin
    i_p0   <= Iout;
    q_p0   <= Qout;
    tag_p0 <= {take_ch, take_bin};
  end

  logic             vld_p2;
  logic [TAG_W-1:0] tag_p2;
  logic [MAG_W-1:0] mag_p2;

  pdb_mag_est #(
    .IQ_W  (IQ_W),
    .TAG_W (TAG_W)
  ) u_mag (
    .clk     (clk),
    .rst     (reset_n),
    .vld     (vld_p0),
    .tag     (tag_p0),
    .i_data  (i_p0),
    .q_data  (q_p0),
    .mag_vld (vld_p2),
    .mag_tag (tag_p2),
    .mag     (mag_p2)
  );

  logic [CH_W-1:0] ch_p2;
  logic [A_W-1:0]  bin_p2;
  logic            in_band_p2;

  assign {ch_p2, bin_p2} = tag_p2;
  assign in_band_p2 = (int'(bin_p2) >= BIN_LO) && (int'(bin_p2) <= BIN_HI);

  // p3: spectrum RAM write and DC / band-peak tracking
  logic [MAG_W-1:0] ram [NUM_CH][FFT_N];
  logic [MAG_W-1:0] dc_p3, peak_mag_p3;
  logic [A_W-1:0]   peak_bin_p3;
  logic [CH_W-1:0]  ch_p3;
  logic             vld_p3, last_p3, rpt_p3;

  always_ff @(posedge clk) begin
    if (vld_p2 && (int'(ch_p2) < NUM_CH)) ram[ch_p2][bin_p2] <= mag_p2;
  end

  always_ff @(posedge clk) begin
    if (reset_n) rd_data <= '0;
    else if (rd_en) rd_data <= (int'(rd_ch) < NUM_CH) ? ram[rd_ch][rd_addr] : '0;
  end

  always_ff @(posedge clk) begin
    if (reset_n) vld_p3 <= 1'b0;
    else         vld_p3 <= vld_p2;
  end

  // Strict greater-than keeps the lowest bin on ties.
  always_ff @(posedge clk) begin
    last_p3 <= (bin_p2 == LAST_BIN);
    ch_p3   <= ch_p2;
    if (vld_p2) begin
      if (bin_p2 == '0) begin
        dc_p3       <= mag_p2;
        peak_mag_p3 <= in_band_p2 ? mag_p2 : '0;
        peak_bin_p3 <= A_W'(BIN_LO);
      end else if (in_band_p2 && (mag_p2 > peak_mag_p3)) begin
        peak_mag_p3 <= mag_p2;
        peak_bin_p3 <= bin_p2;
      end
    end
  end

  assign rpt_p3 = vld_p3 && last_p3;

  // p4: report registers and completion flags
  logic [NUM_CH-1:0] done_flags, flags_nxt;

  always_comb begin
    flags_nxt = done_flags;
    if (pdb_ack) flags_nxt = '0;
    if (rpt_p3 && (int'(ch_p3) < NUM_CH)) flags_nxt[ch_p3] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      AC_component <= '0;
      DC_component <= '0;
      peak_bin     <= '0;
      out_ch       <= '0;
      new_comp_DV  <= 1'b0;
      done_flags   <= '0;
    end else begin
      new_comp_DV <= rpt_p3;
      done_flags  <= flags_nxt;
      if (rpt_p3) begin
        AC_component <= OUT_W'(pdb_shift_sat(64'(peak_mag_p3), SHIFT, OUT_W));
        DC_component <= OUT_W'(pdb_shift_sat(64'(dc_p3), SHIFT, OUT_W));
        peak_bin     <= peak_bin_p3;
        out_ch       <= ch_p3;
      end
    end
  end

  assign pdb_done = &done_flags;

endmodule

// File: tb/tb_pdb_spectral_buffer.sv
// Directed and randomized bench for pdb_spectral_buffer against a frame-level
// reference model (argmax over the band, integer magnitude, spectrum array).
module tb_pdb_spectral_buffer;
  localparam int NUM_CH = 2;
  localparam int FFT_N  = 16;
  localparam int IQ_W   = 24;
  localparam int OUT_W  = 22;
  localparam int SHIFT  = 0;
  localparam int BIN_LO = 1;
  localparam int BIN_HI = 12;
  localparam int CH_W   = 1;
  localparam int A_W    = 4;

  logic                   clk = 1'b0;
  logic                   reset_n, fft_out_data, fft_sop, pdb_ack, rd_en;
  logic [CH_W-1:0]        fft_ch, out_ch, rd_ch;
  logic signed [IQ_W-1:0] Iout, Qout;
  logic [OUT_W-1:0]       AC_component, DC_component;
  logic [A_W-1:0]         peak_bin, rd_addr;
  logic                   new_comp_DV, frame_err, pdb_done;
  logic [IQ_W:0]          rd_data;

  pdb_spectral_buffer #(
    .NUM_CH(NUM_CH), .FFT_N(FFT_N), .IQ_W(IQ_W), .OUT_W(OUT_W),
    .SHIFT(SHIFT), .BIN_LO(BIN_LO), .BIN_HI(BIN_HI)
  ) dut (
    .clk(clk), .reset_n(reset_n), .fft_out_data(fft_out_data), .fft_sop(fft_sop),
    .fft_ch(fft_ch), .Iout(Iout), .Qout(Qout), .AC_component(AC_component),
    .DC_component(DC_component), .peak_bin(peak_bin), .out_ch(out_ch),
    .new_comp_DV(new_comp_DV), .frame_err(frame_err), .pdb_done(pdb_done),
    .pdb_ack(pdb_ack), .rd_en(rd_en), .rd_ch(rd_ch), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ch; int dc; int ac; int pb; int done; int t;
  } rep_t;

  rep_t got_q[$];
  rep_t exp_q[$];
  int   fi [FFT_N];
  int   fq [FFT_N];
  int   ram_m [NUM_CH][FFT_N];
  int   cyc = 0;
  int   last_edge = 0;
  int   err_cnt = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (new_comp_DV)
      got_q.push_back('{int'(out_ch), int'(DC_component), int'(AC_component),
                        int'(peak_bin), int'(pdb_done), cyc});
    if (frame_err) err_cnt++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int mag_of(input int i, input int q);
    int a, b;
    a = (i < 0) ? -i : i;
    b = (q < 0) ? -q : q;
    return (a > b) ? a + b / 2 : b + a / 2;
  endfunction

  function automatic int sat(input int m);
    int v, lim;
    v   = m >>> SHIFT;
    lim = (1 << OUT_W) - 1;
    return (v > lim) ? lim : v;
  endfunction

  function automatic int rnd_val();
    int k;
    k = int'($urandom_range(0, 3));
    case (k)
      0:       return 0;
      1:       return int'($urandom_range(0, 2000)) - 1000;
      2:       return int'($urandom) >>> 8;
      default: return int'($urandom_range(0, 2000000)) - 1000000;
    endcase
  endfunction

  task automatic fill_const(input int i, input int q);
    for (int b = 0; b < FFT_N; b++) begin
      fi[b] = i;
      fq[b] = q;
    end
  endtask

  // Drives nb bins of fi/fq back to back starting with sop; leaves valid high.
  task automatic send_frame(input int ch, input int nb, input bit rdw);
    int   old5, best, pb, m;
    rep_t e;
    old5 = ram_m[ch][5];
    for (int j = 0; j < nb; j++) begin
      @(negedge clk);
      if (rdw && j == 9) begin
        chk("rd_during_wr", 64'(rd_data), 64'(old5));
        rd_en = 1'b0;
      end
      fft_out_data = 1'b1;
      fft_sop      = (j == 0);
      fft_ch       = CH_W'(ch);
      Iout         = IQ_W'(fi[j]);
      Qout         = IQ_W'(fq[j]);
      if (rdw && j == 8) begin
        rd_en   = 1'b1;
        rd_ch   = CH_W'(ch);
        rd_addr = A_W'(5);
      end
      last_edge = cyc + 1;
    end
    for (int j = 0; j < nb; j++) ram_m[ch][j] = mag_of(fi[j], fq[j]);
    if (nb == FFT_N) begin
      best = -1;
      pb   = BIN_LO;
      for (int b = BIN_LO; b <= BIN_HI; b++) begin
        m = mag_of(fi[b], fq[b]);
        if (m > best) begin
          best = m;
          pb   = b;
        end
      end
      e.ch = ch; e.dc = sat(mag_of(fi[0], fq[0])); e.ac = sat(best); e.pb = pb;
      e.done = 0; e.t = last_edge;
      exp_q.push_back(e);
    end
  endtask

  task automatic drain(input string tag);
    rep_t e, g;
    @(negedge clk);
    fft_out_data = 1'b0;
    fft_sop      = 1'b0;
    repeat (8) @(negedge clk);
    chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      chk({tag, "_ch"}, 64'(g.ch), 64'(e.ch));
      chk({tag, "_dc"}, 64'(g.dc), 64'(e.dc));
      chk({tag, "_ac"}, 64'(g.ac), 64'(e.ac));
      chk({tag, "_peak"}, 64'(g.pb), 64'(e.pb));
      chk({tag, "_lat"}, 64'(g.t - e.t), 64'(4));
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic rd_check(input string tag, input int ch, input int a);
    @(negedge clk);
    rd_en   = 1'b1;
    rd_ch   = CH_W'(ch);
    rd_addr = A_W'(a);
    @(negedge clk);
    rd_en = 1'b0;
    chk(tag, 64'(rd_data), 64'(ram_m[ch][a]));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ac"}, 64'(AC_component), 64'(0));
    chk({tag, "_dc"}, 64'(DC_component), 64'(0));
    chk({tag, "_peak"}, 64'(peak_bin), 64'(0));
    chk({tag, "_och"}, 64'(out_ch), 64'(0));
    chk({tag, "_dv"}, 64'(new_comp_DV), 64'(0));
    chk({tag, "_done"}, 64'(pdb_done), 64'(0));
    chk({tag, "_err"}, 64'(frame_err), 64'(0));
    chk({tag, "_rd"}, 64'(rd_data), 64'(0));
  endtask

  initial begin
    rep_t g;
    int   r_ch;
    reset_n = 1'b1; fft_out_data = 1'b0; fft_sop = 1'b0; fft_ch = '0;
    Iout = '0; Qout = '0; pdb_ack = 1'b0; rd_en = 1'b0; rd_ch = '0; rd_addr = '0;
    for (int c = 0; c < NUM_CH; c++) for (int b = 0; b < FFT_N; b++) ram_m[c][b] = 0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset_n = 1'b0;

    // Basic frame: DC 1000, peak 5500 at bin 5
    fill_const(100, 100);
    fi[0] = 1000; fq[0] = 0;
    fi[5] = -3000; fq[5] = 4000;
    send_frame(0, FFT_N, 1'b0);
    drain("basic");
    chk("basic_done", 64'(pdb_done), 64'(0));
    rd_check("rd_bin5", 0, 5);
    chk("rd_bin5_val", 64'(rd_data), 64'(5500));

    // Full-scale negative I/Q saturates the AC output; read-during-write returns old data
    fill_const(100, 100);
    fi[0] = 1000;
    fi[3] = -(1 << 23); fq[3] = -(1 << 23);
    send_frame(0, FFT_N, 1'b1);
    drain("sat");
    rd_check("rd_sat", 0, 3);
    chk("rd_sat_val", 64'(rd_data), 64'(12582912));

    // Ties inside the band keep the lower bin
    fill_const(100, 100);
    fi[0] = 500;
    fi[4] = 2000; fi[9] = 2000; fq[4] = 0; fq[9] = 0;
    send_frame(0, FFT_N, 1'b0);
    drain("tie");

    // ch1 report completes the set
    fill_const(-70, 300);
    send_frame(1, FFT_N, 1'b0);
    exp_q[0].done = 1;
    g = (got_q.size() == 0) ? '{0, 0, 0, 0, 0, 0} : got_q[0];
    repeat (10) @(negedge clk);
    if (got_q.size() > 0) g = got_q[0];
    chk("done_rise", 64'(g.done), 64'(1));
    drain("ch1");
    repeat (5) @(negedge clk);
    chk("done_held", 64'(pdb_done), 64'(1));

    // Ack coincident with a ch0 report: done low, ch0 flag survives
    fill_const(50, -20);
    send_frame(0, FFT_N, 1'b0);
    @(negedge clk);
    fft_out_data = 1'b0;
    fft_sop      = 1'b0;
    while (cyc < last_edge + 3) @(negedge clk);
    pdb_ack = 1'b1;
    @(negedge clk);
    pdb_ack = 1'b0;
    chk("ack_coinc_dv", 64'(new_comp_DV), 64'(1));
    chk("ack_coinc_done", 64'(pdb_done), 64'(0));
    drain("ack");
    fill_const(10, 10);
    send_frame(1, FFT_N, 1'b0);
    drain("ack_ch1");
    chk("done_after_ch1", 64'(pdb_done), 64'(1));
    @(negedge clk);
    pdb_ack = 1'b1;
    @(negedge clk);
    pdb_ack = 1'b0;
    chk("done_ack_clear", 64'(pdb_done), 64'(0));

    // Abort at bin 7, then a full back-to-back frame
    err_cnt = 0;
    for (int b = 0; b < FFT_N; b++) begin fi[b] = 900 - b; fq[b] = b * 7; end
    send_frame(0, 7, 1'b0);
    fi[6] = 44444;
    send_frame(0, FFT_N, 1'b0);
    drain("abort");
    chk("abort_err_pulses", 64'(err_cnt), 64'(1));

    // Reset at bin 10 flushes the frame in flight
    fill_const(3000, -3000);
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      fft_out_data = 1'b1; fft_sop = (j == 0); fft_ch = 1'b1;
      Iout = IQ_W'(fi[j]); Qout = IQ_W'(fq[j]);
    end
    @(negedge clk);
    reset_n = 1'b1;
    fft_sop = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    chk_zero("midrst");
    for (int j = 11; j < FFT_N; j++) begin
      fft_out_data = 1'b1; fft_sop = 1'b0;
      Iout = IQ_W'(fi[j]); Qout = IQ_W'(fq[j]);
      @(negedge clk);
    end
    drain("midrst_none");
    fill_const(-200, 150);
    fi[11] = 7777;
    send_frame(1, FFT_N, 1'b0);
    drain("post_rst");

    // Randomized back-to-back frame pairs plus spectrum read-back
    for (int r = 0; r < 6; r++) begin
      for (int f = 0; f < 2; f++) begin
        for (int b = 0; b < FFT_N; b++) begin
          fi[b] = rnd_val();
          fq[b] = rnd_val();
        end
        if ($urandom_range(0, 1) == 1) begin
          fi[BIN_HI] = fi[BIN_LO + 2];
          fq[BIN_HI] = fq[BIN_LO + 2];
        end
        r_ch = int'($urandom_range(0, NUM_CH - 1));
        send_frame(r_ch, FFT_N, 1'b0);
      end
      drain("rand");
      for (int k = 0; k < 3; k++)
        rd_check("rand_rd", int'($urandom_range(0, NUM_CH - 1)),
                 int'($urandom_range(0, FFT_N - 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
